// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with register file, immediate generator, control decoder and flushable ID/EX register
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        JalrE,
  output logic        ALUSrcE,
  output logic        ALUSrcAE,
  output logic        IllegalE,
  output logic [1:0]  ResultSrcE,
  output logic [3:0]  ALUControlE,
  output logic [2:0]  funct3E,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        jalr;
    logic        alu_src;
    logic        alu_src_a;
    logic        illegal;
    logic [1:0]  result_src;
    logic [3:0]  alu_control;
    logic [2:0]  funct3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } ex_t;
  ex_t ex_d, ex_q;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        alt;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rd1, rd2;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  function automatic logic [3:0] alu_op(input logic [2:0] f, input logic a, input logic sub_ok);
    case (f)
      3'b000:  alu_op = (a && sub_ok) ? 4'b0001 : 4'b0000;
      3'b001:  alu_op = 4'b0101;
      3'b010:  alu_op = 4'b1000;
      3'b011:  alu_op = 4'b1001;
      3'b100:  alu_op = 4'b0100;
      3'b101:  alu_op = a ? 4'b0111 : 4'b0110;
      3'b110:  alu_op = 4'b0011;
      default: alu_op = 4'b0010;
    endcase
  endfunction
  assign op    = instrD[6:0];
  assign f3    = instrD[14:12];
  assign alt   = instrD[30];
  assign rs1   = instrD[19:15];
  assign rs2   = instrD[24:20];
  assign rd    = instrD[11:7];
  assign Rs1D  = rs1;
  assign Rs2D  = rs2;
  assign imm_i = {{20{instrD[31]}}, instrD[31:20]};
  assign imm_s = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
  assign imm_b = {{20{instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
  assign imm_j = {{12{instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
  assign imm_u = {instrD[31:12], 12'b0};
  assign rd1   = rs1 == 5'd0 ? 32'd0 : (RegWriteW && RdW == rs1) ? ResultW : regs_q[rs1];
  assign rd2   = rs2 == 5'd0 ? 32'd0 : (RegWriteW && RdW == rs2) ? ResultW : regs_q[rs2];
  always_comb begin
    regs_d = regs_q;
    if (RegWriteW && RdW != 5'd0) regs_d[RdW] = ResultW;
  end
  always_comb begin
    ex_d          = '0;
    ex_d.funct3   = f3;
    ex_d.rd1      = rd1;
    ex_d.rd2      = rd2;
    ex_d.pc       = PCD;
    ex_d.pc_plus4 = PCPlus4D;
    ex_d.rs1      = rs1;
    ex_d.rs2      = rs2;
    ex_d.rd       = rd;
    case (op)
      OP_R: begin
        ex_d.reg_write   = 1'b1;
        ex_d.alu_control = alu_op(f3, alt, 1'b1);
      end
      OP_I: begin
        ex_d.reg_write   = 1'b1;
        ex_d.alu_src     = 1'b1;
        ex_d.alu_control = alu_op(f3, alt, 1'b0);
        ex_d.imm         = imm_i;
      end
      OP_LOAD: begin
        ex_d.reg_write  = 1'b1;
        ex_d.alu_src    = 1'b1;
        ex_d.result_src = 2'b01;
        ex_d.imm        = imm_i;
      end
      OP_STORE: begin
        ex_d.mem_write = 1'b1;
        ex_d.alu_src   = 1'b1;
        ex_d.imm       = imm_s;
      end
      OP_BR: begin
        ex_d.branch      = 1'b1;
        ex_d.alu_control = 4'b0001;
        ex_d.imm         = imm_b;
      end
      OP_JAL: begin
        ex_d.reg_write  = 1'b1;
        ex_d.jump       = 1'b1;
        ex_d.result_src = 2'b10;
        ex_d.imm        = imm_j;
      end
      OP_JALR: begin
        ex_d.reg_write  = 1'b1;
        ex_d.jalr       = 1'b1;
        ex_d.alu_src    = 1'b1;
        ex_d.result_src = 2'b10;
        ex_d.imm        = imm_i;
      end
      OP_LUI: begin
        ex_d.reg_write   = 1'b1;
        ex_d.alu_src     = 1'b1;
        ex_d.alu_control = 4'b1010;
        ex_d.imm         = imm_u;
      end
      OP_AUIPC: begin
        ex_d.reg_write = 1'b1;
        ex_d.alu_src   = 1'b1;
        ex_d.alu_src_a = 1'b1;
        ex_d.imm       = imm_u;
      end
      default: ex_d.illegal = 1'b1;
    endcase
    if (FlushE) ex_d = '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q   <= '0;
      regs_q <= '{default: '0};
    end else begin
      ex_q   <= ex_d;
      regs_q <= regs_d;
    end
  end
  assign RegWriteE   = ex_q.reg_write;
  assign MemWriteE   = ex_q.mem_write;
  assign JumpE       = ex_q.jump;
  assign BranchE     = ex_q.branch;
  assign JalrE       = ex_q.jalr;
  assign ALUSrcE     = ex_q.alu_src;
  assign ALUSrcAE    = ex_q.alu_src_a;
  assign IllegalE    = ex_q.illegal;
  assign ResultSrcE  = ex_q.result_src;
  assign ALUControlE = ex_q.alu_control;
  assign funct3E     = ex_q.funct3;
  assign RD1E        = ex_q.rd1;
  assign RD2E        = ex_q.rd2;
  assign ImmExtE     = ex_q.imm;
  assign PCE         = ex_q.pc;
  assign PCPlus4E    = ex_q.pc_plus4;
  assign Rs1E        = ex_q.rs1;
  assign Rs2E        = ex_q.rs2;
  assign RdE         = ex_q.rd;
endmodule
